// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// encoding and the access-size / legality helpers.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_D    = 3'b011;
    localparam logic [2:0] F3_WU   = 3'b110;
    localparam logic [2:0] F3_RSVD = 3'b111;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        REQ0  = 6'b000010,
        RESP0 = 6'b000100,
        REQ1  = 6'b001000,
        RESP1 = 6'b010000,
        DONE  = 6'b100000
    } lsu_state_t;

    function automatic logic [3:0] lsu_size(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

    // Doubleword and unsigned-word forms only exist on RV64.
    function automatic logic lsu_illegal(input logic [2:0] funct3, input logic is_store,
                                         input int xlen);
        logic bad;
        bad = (funct3 == F3_RSVD) || (is_store && funct3[2]);
        if (xlen == 32 && (funct3 == F3_D || funct3 == F3_WU))
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/riscv_lsu_lane_align.sv
// Combinational byte-lane steering: store data/strobe shifting across two beats
// and load merge, extraction and sign/zero extension.
module lsu_lane_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [OFFW-1:0] off,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] beat0,
    input  logic [XLEN-1:0] beat1,
    output logic [XLEN-1:0] wdata0,
    output logic [XLEN-1:0] wdata1,
    output logic [NB-1:0]   strb0,
    output logic [NB-1:0]   strb1,
    output logic [XLEN-1:0] rdata
);

    logic [3:0]        size;
    logic [2*XLEN-1:0] wide_w;
    logic [2*XLEN-1:0] wide_d;
    logic [2*NB-1:0]   mask;
    logic [2*NB-1:0]   wide_s;
    logic              sign_bit;

    assign size = lsu_size(funct3);

    always_comb begin
        wide_w = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        mask = '0;
        for (int i = 0; i < 2*NB; i++)
            mask[i] = (i < int'(size));
        wide_s = mask << off;
        wdata0 = wide_w[XLEN-1:0];
        wdata1 = wide_w[2*XLEN-1:XLEN];
        strb0  = wide_s[NB-1:0];
        strb1  = wide_s[2*NB-1:NB];
    end

    // Bytes above the access size are filled with the sign bit (0 for unsigned forms).
    always_comb begin
        wide_d = {beat1, beat0} >> {off, 3'b000};
        case ({1'b0, funct3[1:0]})
            F3_B:    sign_bit = wide_d[7];
            F3_H:    sign_bit = wide_d[15];
            F3_W:    sign_bit = wide_d[31];
            default: sign_bit = wide_d[XLEN-1];
        endcase
        if (funct3[2])
            sign_bit = 1'b0;
        rdata = '0;
        for (int i = 0; i < NB; i++)
            rdata[8*i +: 8] = (i < int'(size)) ? wide_d[8*i +: 8] : {8{sign_bit}};
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one access per transaction, split into up to two bus beats,
// with memory-side performance counters.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_is_store,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   Address,
    output logic                MemWrite,
    output logic [XLEN-1:0]     Write_data,
    output logic [XLEN/8-1:0]   Write_strb,
    output logic                MemRead,
    input  logic                Mem_Req_Ready,
    input  logic [XLEN-1:0]     Read_data,
    input  logic                Read_data_Valid,
    output logic                Read_data_Ready,
    output logic [CNT_W-1:0]    ld_cnt,
    output logic [CNT_W-1:0]    st_cnt,
    output logic [CNT_W-1:0]    split_cnt,
    output logic [CNT_W-1:0]    req_stall_cnt,
    output logic [CNT_W-1:0]    rdw_stall_cnt
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_t        state;
    logic              is_store_q;
    logic              split_q;
    logic              err_q;
    logic [2:0]        funct3_q;
    logic [OFFW-1:0]   off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   beat0_q;
    logic [XLEN-1:0]   beat1_q;

    logic [OFFW-1:0]   req_off;
    logic              req_cross;
    logic              req_bad;
    logic              in_req;
    logic [XLEN-1:0]   st_w0, st_w1, ld_data;
    logic [NB-1:0]     st_s0, st_s1;

    assign req_off   = req_addr[OFFW-1:0];
    assign req_cross = (int'(req_off) + int'(lsu_size(req_funct3))) > NB;
    assign req_bad   = lsu_illegal(req_funct3, req_is_store, XLEN) ||
                       (req_cross && MISALIGN_SPLIT == 0);

    // Single FSM also owns the captured request, the read beats and the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            is_store_q    <= 1'b0;
            split_q       <= 1'b0;
            err_q         <= 1'b0;
            funct3_q      <= '0;
            off_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            beat0_q       <= '0;
            beat1_q       <= '0;
            ld_cnt        <= '0;
            st_cnt        <= '0;
            split_cnt     <= '0;
            req_stall_cnt <= '0;
            rdw_stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        off_q      <= req_off;
                        addr_q     <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                        wdata_q    <= req_wdata;
                        beat0_q    <= '0;
                        beat1_q    <= '0;
                        split_q    <= req_cross;
                        err_q      <= req_bad;
                        if (req_bad) begin
                            state <= DONE;
                        end else begin
                            state <= REQ0;
                            if (req_is_store)
                                st_cnt <= st_cnt + CNT_W'(1);
                            else
                                ld_cnt <= ld_cnt + CNT_W'(1);
                            if (req_cross)
                                split_cnt <= split_cnt + CNT_W'(1);
                        end
                    end
                end
                REQ0, REQ1: begin
                    if (Mem_Req_Ready) begin
                        if (!is_store_q) begin
                            state <= (state == REQ0) ? RESP0 : RESP1;
                        end else if (state == REQ0 && split_q) begin
                            state  <= REQ1;
                            addr_q <= addr_q + ADDR_W'(NB);
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        req_stall_cnt <= req_stall_cnt + CNT_W'(1);
                    end
                end
                RESP0: begin
                    if (Read_data_Valid) begin
                        beat0_q <= Read_data;
                        if (split_q) begin
                            state  <= REQ1;
                            addr_q <= addr_q + ADDR_W'(NB);
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        rdw_stall_cnt <= rdw_stall_cnt + CNT_W'(1);
                    end
                end
                RESP1: begin
                    if (Read_data_Valid) begin
                        beat1_q <= Read_data;
                        state   <= DONE;
                    end else begin
                        rdw_stall_cnt <= rdw_stall_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .off    (off_q),
        .funct3 (funct3_q),
        .wdata  (wdata_q),
        .beat0  (beat0_q),
        .beat1  (beat1_q),
        .wdata0 (st_w0),
        .wdata1 (st_w1),
        .strb0  (st_s0),
        .strb1  (st_s1),
        .rdata  (ld_data)
    );

    // Handshake outputs decode directly from the one-hot state flops.
    assign in_req          = (state == REQ0) || (state == REQ1);
    assign req_ready       = (state == IDLE);
    assign MemRead         = in_req && !is_store_q;
    assign MemWrite        = in_req && is_store_q;
    assign Read_data_Ready = (state == RESP0) || (state == RESP1);
    assign resp_valid      = (state == DONE);
    assign resp_err        = (state == DONE) && err_q;
    assign resp_rdata      = (state == DONE && !is_store_q && !err_q) ? ld_data : '0;
    assign Address         = addr_q;
    assign Write_data      = MemWrite ? ((state == REQ1) ? st_w1 : st_w0) : '0;
    assign Write_strb      = MemWrite ? ((state == REQ1) ? st_s1 : st_s0) : '0;

endmodule
